tcam_lookup: RTL and testbench
==============================

TCAM_LOOKUP -- requirements
Module: tcam_lookup

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, search/entry key width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, log2 of entry count (DEPTH = 2**ADDR_WIDTH).
REQ-003 SHALL have ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- write_addr  input  ADDR_WIDTH  target entry.
- write_data  input  DATA_WIDTH  key to store.
- write_mask  input  DATA_WIDTH  care bits (1 = compare, 0 = don't care).
- write_delete  input  1  1 = invalidate entry instead of store.
- write_enable  input  1  write request.
- write_busy  output  1  write port not accepting.
- search_data  input  DATA_WIDTH  key to look up.
- search_valid  input  1  search request.
- search_ready  output  1  search port accepting.
- match_valid  output  1  result strobe, one cycle per search.
- match  output  1  at least one entry hit.
- match_addr  output  ADDR_WIDTH  lowest hit index.
- match_many  output  DEPTH  raw hit vector.
- match_single  output  DEPTH  one-hot of lowest hit.

Function
REQ-004 Entry state SHALL be key, mask and valid bit, held in registers.
REQ-005 Entry i SHALL hit iff valid[i] and ((search_data XOR key[i]) AND mask[i]) == 0; mask all-zero valid entry hits every key.
REQ-006 Write SHALL be accepted on a cycle with write_enable=1 and write_busy=0; array updates at that edge.
REQ-007 Accepted store SHALL set key, mask, valid=1; accepted delete SHALL clear valid only.
REQ-008 write_busy SHALL be 1 for exactly the one cycle after each accepted write, else 0; write_enable while busy is ignored (not queued).
REQ-009 search_ready SHALL equal NOT write_busy.
REQ-010 Search SHALL be accepted on a cycle with search_valid=1 and search_ready=1.
REQ-011 Search SHALL compare against array contents before that edge; a write accepted in the same cycle SHALL NOT be visible to it, and SHALL be visible to searches accepted later.
REQ-012 Pipeline: stage 1 registers hit vector; stage 2 registers priority-encoded outputs; match_valid SHALL assert exactly 2 cycles after acceptance.
REQ-013 Back-to-back searches SHALL sustain one result per cycle; no output backpressure; results in acceptance order.
REQ-014 match_single SHALL be one-hot of lowest set bit of match_many, or 0; match_addr SHALL be its index, 0 when no hit.
REQ-015 Outputs SHALL hold last values while match_valid=0.
REQ-016 Overwriting a valid entry SHALL replace key and mask with no intermediate invalid state.

Reset
REQ-017 rst SHALL clear all valid bits; key/mask contents unspecified.
REQ-018 rst SHALL clear pipeline: match_valid, match, match_addr, match_many, match_single = 0; in-flight searches dropped, no result emitted.
REQ-019 After reset write_busy=0, search_ready=1; rst has priority over simultaneous write or search.

Configuration
REQ-020 Macro TCAM_LOOKUP_FREE_ALLOC_EN SHALL add input write_auto (1) and outputs free_addr (ADDR_WIDTH), full (1).
REQ-021 With macro: free_addr = lowest invalid index (0 if full), full = all valid, both registered and updated the cycle after any write; accepted write with write_auto=1 SHALL use free_addr instead of write_addr; auto store when full SHALL be dropped and still assert write_busy.
REQ-022 Without macro: those ports SHALL not exist; writes always use write_addr.

Verification
REQ-023 Reset, store key 0x00000000_000000AB mask all-ones at 3; search 0xAB -> 2 cycles later match_valid=1, match=1, match_addr=3, match_many=0x00000008.
REQ-024 Entry 5 key 0xF0 mask 0xF0, entry 9 key 0xF5 mask all-ones; search 0xF5 -> match_many=0x220, match_single=0x20, match_addr=5.
REQ-025 Same-cycle write of key 0x11 to entry 2 and search 0x11 on empty array -> match=0; next search 0x11 -> match=1, match_addr=2.
REQ-026 Write accepted, write_enable held 2 cycles -> write_busy=1 and search_ready=0 second cycle, second write ignored; 4 consecutive searches -> 4 match_valid pulses in order.
REQ-027 Delete entry 3 then search 0xAB -> match=0, match_addr=0; rst asserted one cycle after search accept -> no match_valid pulse.
REQ-028 With TCAM_LOOKUP_FREE_ALLOC_EN, DEPTH auto stores -> addresses 0..31, full=1; extra auto store dropped; delete entry 7 -> free_addr=7, full=0.

Source files
------------

// File: rtl/tcam_lookup.sv
// tcam_lookup: register-based ternary CAM with a two-stage search pipeline.
//
// Parameters
//   DATA_WIDTH  key width in bits
//   ADDR_WIDTH  log2 of entry count (DEPTH = 2**ADDR_WIDTH)
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   write_*         single-entry store/delete port; write_busy is high for
//                   one cycle after every accepted write
//   search_data/valid/ready  lookup request (ready = !write_busy)
//   match_valid     one-cycle strobe, two cycles after search acceptance
//   match, match_addr, match_many, match_single
//                   any-hit flag, lowest hit index, raw hit vector, one-hot
//                   of the lowest hit; all hold between strobes
//
// Optional feature (macro TCAM_LOOKUP_FREE_ALLOC_EN)
//   write_auto      store into free_addr instead of write_addr
//   free_addr, full lowest invalid entry / all-valid flag, registered
module tcam_lookup #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [DATA_WIDTH-1:0]    write_mask,
  input  logic                     write_delete,
  input  logic                     write_enable,
  output logic                     write_busy,
  input  logic [DATA_WIDTH-1:0]    search_data,
  input  logic                     search_valid,
  output logic                     search_ready,
  output logic                     match_valid,
  output logic                     match,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic [(2**ADDR_WIDTH)-1:0] match_many,
  output logic [(2**ADDR_WIDTH)-1:0] match_single
`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
  ,
  input  logic                     write_auto,
  output logic [ADDR_WIDTH-1:0]    free_addr,
  output logic                     full
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] key_q  [DEPTH];
  logic [DATA_WIDTH-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  logic                  wr_acc;
  logic                  wr_do;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  search_acc;
  logic [DEPTH-1:0]      hits;

  logic                  s1_valid;
  logic [DEPTH-1:0]      s1_hits;
  logic                  enc_found;
  logic [ADDR_WIDTH-1:0] enc_addr;
  logic [DEPTH-1:0]      enc_onehot;

  assign search_ready = ~write_busy;
  assign wr_acc       = write_enable & ~write_busy;
  assign search_acc   = search_valid & search_ready;

`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
  logic                  free_found;
  logic [ADDR_WIDTH-1:0] free_idx;

  // An auto store into a full table is still accepted (and so still raises
  // write_busy) but leaves the array untouched.
  assign wr_idx = write_auto ? free_addr : write_addr;
  assign wr_do  = wr_acc & ~(write_auto & ~write_delete & full);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = ADDR_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_addr <= '0;
      full      <= 1'b0;
    end else begin
      free_addr <= free_idx;
      full      <= &valid_q;
    end
  end
`else
  assign wr_idx = write_addr;
  assign wr_do  = wr_acc;
`endif

  // Valid bits and the write-port busy flag; reset wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      write_busy <= 1'b0;
    end else begin
      write_busy <= wr_acc;
      if (wr_do) begin
        valid_q[wr_idx] <= ~write_delete;
      end
    end
  end

  // Key and mask storage needs no reset; a store overwrites both in the same
  // edge that sets valid, so an overwrite never passes through invalid.
  always_ff @(posedge clk) begin
    if (!rst && wr_do && !write_delete) begin
      key_q[wr_idx]  <= write_data;
      mask_q[wr_idx] <= write_mask;
    end
  end

  // Compare against pre-edge contents: a write landing on the same edge as
  // the search is not seen by it.
  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hits[i] = valid_q[i] && (((search_data ^ key_q[i]) & mask_q[i]) == '0);
    end
  end

  // Lowest-index priority encode of the stage-1 hit vector.
  always_comb begin
    enc_found  = 1'b0;
    enc_addr   = '0;
    enc_onehot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (s1_hits[i] && !enc_found) begin
        enc_found     = 1'b1;
        enc_addr      = ADDR_WIDTH'(i);
        enc_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_hits      <= '0;
      match_valid  <= 1'b0;
      match        <= 1'b0;
      match_addr   <= '0;
      match_many   <= '0;
      match_single <= '0;
    end else begin
      s1_valid    <= search_acc;
      match_valid <= s1_valid;
      if (search_acc) begin
        s1_hits <= hits;
      end
      if (s1_valid) begin
        match        <= enc_found;
        match_addr   <= enc_addr;
        match_many   <= s1_hits;
        match_single <= enc_onehot;
      end
    end
  end

endmodule

// File: tb/tb_tcam_lookup.sv
module tb_tcam_lookup;

  logic        clk;
  logic        rst;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  logic [63:0] write_mask;
  logic        write_delete;
  logic        write_enable;
  logic        write_busy;
  logic [63:0] search_data;
  logic        search_valid;
  logic        search_ready;
  logic        match_valid;
  logic        match;
  logic [4:0]  match_addr;
  logic [31:0] match_many;
  logic [31:0] match_single;
`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
  logic        write_auto;
  logic [4:0]  free_addr;
  logic        full;
`endif

  int checks = 0;
  int errors = 0;
  logic mv_early;

  localparam logic [63:0] ONES = '1;

  tcam_lookup #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
    .write_delete(write_delete), .write_enable(write_enable), .write_busy(write_busy),
    .search_data(search_data), .search_valid(search_valid), .search_ready(search_ready),
    .match_valid(match_valid), .match(match), .match_addr(match_addr),
    .match_many(match_many), .match_single(match_single)
`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
    , .write_auto(write_auto), .free_addr(free_addr), .full(full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus drivers (no checking inside).
  task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic [63:0] m,
                          input logic del);
    write_addr = a; write_data = d; write_mask = m; write_delete = del; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0; write_delete = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_search(input logic [63:0] k);
    search_data = k; search_valid = 1'b1;
    @(posedge clk); #1;
    search_valid = 1'b0;
    mv_early = match_valid;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (match_valid !== 1'b0) begin errors++; $display("FAIL reset_mv: got %b expected 0", match_valid); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b expected 0", match); end
    checks++; if (match_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", match_addr); end
    checks++; if (match_many !== 32'h0) begin errors++; $display("FAIL reset_many: got %h expected 0", match_many); end
    checks++; if (match_single !== 32'h0) begin errors++; $display("FAIL reset_single: got %h expected 0", match_single); end
    checks++; if (write_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", write_busy); end
    checks++; if (search_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", search_ready); end
  endtask

  task automatic test_same_cycle();
    write_addr = 5'd2; write_data = 64'h11; write_mask = ONES; write_delete = 1'b0;
    write_enable = 1'b1; search_data = 64'h11; search_valid = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0; search_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (match_valid !== 1'b1) begin errors++; $display("FAIL same_mv: got %b expected 1", match_valid); end
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL same_match: got %b expected 0", match); end
    run_search(64'h11);
    checks++; if (match !== 1'b1 || match_addr !== 5'd2) begin errors++; $display("FAIL after_same: got match=%b addr=%0d expected 1/2", match, match_addr); end
  endtask

  task automatic test_basic();
    write_addr = 5'd3; write_data = 64'hAB; write_mask = ONES; write_delete = 1'b0; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
    checks++; if (write_busy !== 1'b1 || search_ready !== 1'b0) begin errors++; $display("FAIL busy_after_write: got busy=%b ready=%b expected 1/0", write_busy, search_ready); end
    @(posedge clk); #1;
    checks++; if (write_busy !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b expected 0", write_busy); end
    run_search(64'hAB);
    checks++; if (mv_early !== 1'b0) begin errors++; $display("FAIL basic_latency: mv after 1 cycle got %b expected 0", mv_early); end
    checks++; if (match_valid !== 1'b1) begin errors++; $display("FAIL basic_mv: got %b expected 1", match_valid); end
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL basic_match: got %b expected 1", match); end
    checks++; if (match_addr !== 5'd3) begin errors++; $display("FAIL basic_addr: got %0d expected 3", match_addr); end
    checks++; if (match_many !== 32'h8) begin errors++; $display("FAIL basic_many: got %h expected 00000008", match_many); end
    checks++; if (match_single !== 32'h8) begin errors++; $display("FAIL basic_single: got %h expected 00000008", match_single); end
    @(posedge clk); #1;
    checks++; if (match_valid !== 1'b0) begin errors++; $display("FAIL hold_mv: got %b expected 0", match_valid); end
    checks++; if (match_addr !== 5'd3 || match !== 1'b1) begin errors++; $display("FAIL hold_out: got match=%b addr=%0d expected 1/3", match, match_addr); end
  endtask

  task automatic test_priority();
    do_write(5'd5, 64'hF0, 64'hF0, 1'b0);
    do_write(5'd9, 64'hF5, ONES, 1'b0);
    run_search(64'hF5);
    checks++; if (match_many !== 32'h220) begin errors++; $display("FAIL prio_many: got %h expected 00000220", match_many); end
    checks++; if (match_single !== 32'h20) begin errors++; $display("FAIL prio_single: got %h expected 00000020", match_single); end
    checks++; if (match_addr !== 5'd5) begin errors++; $display("FAIL prio_addr: got %0d expected 5", match_addr); end
    run_search(64'hF7);
    checks++; if (match_many !== 32'h20 || match_addr !== 5'd5) begin errors++; $display("FAIL masked_hit: got many=%h addr=%0d expected 00000020/5", match_many, match_addr); end
    run_search(64'h0F);
    checks++; if (match !== 1'b0 || match_addr !== 5'd0 || match_many !== 32'h0 || match_single !== 32'h0) begin
      errors++; $display("FAIL no_hit: got match=%b addr=%0d many=%h single=%h expected all 0", match, match_addr, match_many, match_single); end
    do_write(5'd31, 64'h123, 64'h0, 1'b0);
    run_search(64'h0F);
    checks++; if (match_many !== 32'h8000_0000 || match_addr !== 5'd31 || match_single !== 32'h8000_0000) begin
      errors++; $display("FAIL zero_mask_top: got many=%h addr=%0d single=%h expected 80000000/31/80000000", match_many, match_addr, match_single); end
    do_write(5'd31, 64'h0, 64'h0, 1'b1);
    run_search(64'h0F);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL del_31: got %b expected 0", match); end
    do_write(5'd5, 64'hF4, ONES, 1'b0);
    run_search(64'hF7);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL overwrite_old: got %b expected 0", match); end
    run_search(64'hF4);
    checks++; if (match_many !== 32'h20) begin errors++; $display("FAIL overwrite_new: got %h expected 00000020", match_many); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_addr [4];
    logic       exp_hit  [4];
    logic [63:0] keys    [4];
    keys[0] = 64'hAB; exp_addr[0] = 5'd3;  exp_hit[0] = 1'b1;
    keys[1] = 64'h55; exp_addr[1] = 5'd10; exp_hit[1] = 1'b1;
    keys[2] = 64'h11; exp_addr[2] = 5'd2;  exp_hit[2] = 1'b1;
    keys[3] = 64'h99; exp_addr[3] = 5'd0;  exp_hit[3] = 1'b0;
    write_addr = 5'd10; write_data = 64'h55; write_mask = ONES; write_delete = 1'b0; write_enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (write_busy !== 1'b1 || search_ready !== 1'b0) begin errors++; $display("FAIL held_busy: got busy=%b ready=%b expected 1/0", write_busy, search_ready); end
    write_addr = 5'd11; write_data = 64'h66;
    @(posedge clk); #1;
    write_enable = 1'b0;
    checks++; if (write_busy !== 1'b0) begin errors++; $display("FAIL held_ignored_busy: got %b expected 0", write_busy); end
    run_search(64'h66);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL held_ignored: got %b expected 0", match); end
    for (int i = 0; i < 6; i++) begin
      search_valid = (i < 4);
      if (i < 4) search_data = keys[i];
      @(posedge clk); #1;
      if (i >= 1 && i <= 4) begin
        checks++; if (match_valid !== 1'b1 || match !== exp_hit[i-1] || match_addr !== exp_addr[i-1]) begin
          errors++; $display("FAIL b2b_%0d: got mv=%b match=%b addr=%0d expected 1/%b/%0d", i-1, match_valid, match, match_addr, exp_hit[i-1], exp_addr[i-1]); end
      end else begin
        checks++; if (match_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d: got mv=%b expected 0", i, match_valid); end
      end
    end
    search_valid = 1'b0;
  endtask

  task automatic test_delete_reset();
    do_write(5'd3, 64'h0, 64'h0, 1'b1);
    run_search(64'hAB);
    checks++; if (match !== 1'b0 || match_addr !== 5'd0 || match_many !== 32'h0) begin
      errors++; $display("FAIL delete: got match=%b addr=%0d many=%h expected 0/0/0", match, match_addr, match_many); end
    run_search(64'h55);
    checks++; if (match !== 1'b1 || match_addr !== 5'd10) begin errors++; $display("FAIL pre_rst_hit: got %b/%0d expected 1/10", match, match_addr); end
    search_data = 64'h55; search_valid = 1'b1;
    @(posedge clk); #1;
    search_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (match_valid !== 1'b0 || match !== 1'b0 || match_addr !== 5'd0 || match_many !== 32'h0) begin
      errors++; $display("FAIL rst_flush: got mv=%b match=%b addr=%0d many=%h expected 0", match_valid, match, match_addr, match_many); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (match_valid !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got %b expected 0", match_valid); end
    rst = 1'b1;
    write_addr = 5'd4; write_data = 64'h44; write_mask = ONES; write_enable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; write_enable = 1'b0;
    checks++; if (write_busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy: got %b expected 0", write_busy); end
    run_search(64'h55);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL rst_cleared: got %b expected 0", match); end
    run_search(64'h44);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL rst_prio_write: got %b expected 0", match); end
  endtask

`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
  task automatic test_free_alloc();
    apply_reset();
    checks++; if (free_addr !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL free_reset: got %0d/%b expected 0/0", free_addr, full); end
    write_auto = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++; if (free_addr !== 5'(i)) begin errors++; $display("FAIL free_addr_%0d: got %0d expected %0d", i, free_addr, i); end
      do_write(5'd0, 64'h100 + 64'(i), ONES, 1'b0);
    end
    checks++; if (full !== 1'b1 || free_addr !== 5'd0) begin errors++; $display("FAIL full: got full=%b free=%0d expected 1/0", full, free_addr); end
    write_data = 64'h999; write_mask = ONES; write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
    checks++; if (write_busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", write_busy); end
    @(posedge clk); #1;
    write_auto = 1'b0;
    run_search(64'h999);
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL full_drop: got %b expected 0", match); end
    run_search(64'h11F);
    checks++; if (match_addr !== 5'd31 || match !== 1'b1) begin errors++; $display("FAIL auto_31: got %b/%0d expected 1/31", match, match_addr); end
    run_search(64'h107);
    checks++; if (match_addr !== 5'd7 || match !== 1'b1) begin errors++; $display("FAIL auto_7: got %b/%0d expected 1/7", match, match_addr); end
    do_write(5'd7, 64'h0, 64'h0, 1'b1);
    checks++; if (free_addr !== 5'd7 || full !== 1'b0) begin errors++; $display("FAIL free_after_del: got %0d/%b expected 7/0", free_addr, full); end
  endtask
`endif

  initial begin
    rst = 1'b1; write_addr = '0; write_data = '0; write_mask = '0; write_delete = 1'b0;
    write_enable = 1'b0; search_data = '0; search_valid = 1'b0; mv_early = 1'b0;
`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
    write_auto = 1'b0;
`endif
    test_reset();
    test_same_cycle();
    test_basic();
    test_priority();
    test_back_to_back();
    test_delete_reset();
`ifdef TCAM_LOOKUP_FREE_ALLOC_EN
    test_free_alloc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
